// File: rtl/pixel_stream_framer.sv
// Tags a free-running pixel stream with sof/eol/eof, buffers it and re-emits it as a framed
// valid/ready stream. Define PIXEL_STREAM_FRAMER_STATS_EN to add a saturating drop_count output.
module pixel_stream_framer #(
  parameter int IMAGE_WIDTH      = 1280,
  parameter int IMAGE_HEIGHT     = 360,
  parameter int PIXEL_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [PIXEL_DATA_WIDTH-1:0] s_pixel_data,
  input  logic                        s_pixel_valid,
  output logic [PIXEL_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  input  logic                        clr_overflow,
  output logic                        overflow,
  output logic                        frame_done,
`ifdef PIXEL_STREAM_FRAMER_STATS_EN
  output logic [15:0]                 drop_count,
`endif
  output logic                        dbg_state_o
);

  // Handshake: a word moves on m_axis when tvalid && tready in the same cycle; tvalid and the
  // payload hold until that happens. The input side has no ready and is never stalled.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PIXEL_DATA_WIDTH + 3;
  localparam logic [10:0]   COL_LAST = 11'(IMAGE_WIDTH - 1);
  localparam logic [10:0]   ROW_LAST = 11'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       col_q, col_d;
  logic [10:0]       row_q, row_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [EW-1:0]     out_q, out_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic [EW-1:0]     mem [FIFO_DEPTH];

  logic          tag_sof, tag_eol, tag_eof;
  logic [EW-1:0] wr_word;
  logic          handshake, load_slot, fifo_empty, fifo_full;
  logic          pop, bypass, push, drop;

  assign tag_sof = (row_q == 11'd0) && (col_q == 11'd0);
  assign tag_eol = (col_q == COL_LAST);
  assign tag_eof = tag_eol && (row_q == ROW_LAST);
  assign wr_word = {s_pixel_data, tag_sof, tag_eol, tag_eof};

  assign handshake  = (state_q == ST_LOADED) && m_axis_tready;
  assign load_slot  = (state_q == ST_EMPTY) || handshake;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign pop        = load_slot && !fifo_empty;
  // An empty FIFO with a free output slot forwards the pixel straight to the register,
  // giving one-cycle latency and gap-free streaming.
  assign bypass     = load_slot && fifo_empty && s_pixel_valid;
  assign push       = s_pixel_valid && (!fifo_full || pop) && !bypass;
  assign drop       = s_pixel_valid && fifo_full && !pop;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (s_pixel_valid) begin
      if (col_q == COL_LAST) begin
        col_d = 11'd0;
        row_d = (row_q == ROW_LAST) ? 11'd0 : row_q + 11'd1;
      end else begin
        col_d = col_q + 11'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop) begin
      out_d   = mem[rd_ptr_q];
      state_d = ST_LOADED;
    end else if (bypass) begin
      out_d   = wr_word;
      state_d = ST_LOADED;
    end else if (handshake) begin
      state_d = ST_EMPTY;
    end
    frame_done_d = handshake && out_q[0];
    overflow_d   = drop || (overflow_q && !clr_overflow);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_EMPTY;
      col_q        <= '0;
      row_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_word;
  end

`ifdef PIXEL_STREAM_FRAMER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A drop in the same cycle as a clear restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (clr_overflow)                drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_overflow) begin
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  assign m_axis_tdata  = out_q[EW-1:3];
  assign m_axis_tuser  = out_q[2];
  assign m_axis_tlast  = out_q[1];
  assign m_axis_tvalid = (state_q == ST_LOADED);
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Bench for pixel_stream_framer on a 4x3 image with a 4-entry FIFO: directed scenarios then
// random traffic, checked against a queue model of D+1 storage slots with index-derived tags.
module tb_pixel_stream_framer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int D     = 4;
  localparam int PW    = 16;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [PW-1:0] s_pixel_data = '0;
  logic          s_pixel_valid = 1'b0;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          clr_overflow = 1'b0;
  logic          overflow;
  logic          frame_done;
  logic          dbg_state;
`ifdef PIXEL_STREAM_FRAMER_STATS_EN
  logic [15:0]   drop_count;
`endif

  pixel_stream_framer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_DATA_WIDTH(PW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_pixel_data(s_pixel_data), .s_pixel_valid(s_pixel_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .clr_overflow(clr_overflow), .overflow(overflow), .frame_done(frame_done),
`ifdef PIXEL_STREAM_FRAMER_STATS_EN
    .drop_count(drop_count),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: each entry is {data, sof, eol, eof}
  logic [PW+2:0] exp_q[$];
  int            pix_n;
  int            n_vec;
  int            n_err;
  logic          exp_ovf;
  logic          exp_fd;
  logic [15:0]   exp_dc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pix_n   = 0;
    exp_ovf = 1'b0;
    exp_fd  = 1'b0;
    exp_dc  = '0;
  endtask

  // Advances the model across one rising edge with the given inputs.
  task automatic model_step(input bit v, input logic [PW-1:0] d, input bit r, input bit c);
    logic [PW+2:0] w;
    bit hs, dropped;
    int pos;
    hs      = (exp_q.size() > 0) && r;
    exp_fd  = 1'b0;
    dropped = 1'b0;
    if (hs) begin
      w      = exp_q.pop_front();
      exp_fd = w[0];
    end
    if (v) begin
      pos = pix_n % TOTAL;
      if (exp_q.size() < D + 1)
        exp_q.push_back({d, pos == 0, (pos % W) == W - 1, pos == TOTAL - 1});
      else
        dropped = 1'b1;
      pix_n++;
    end
    if (dropped) begin
      exp_ovf = 1'b1;
      if (c)                    exp_dc = 16'd1;
      else if (exp_dc != 16'hFFFF) exp_dc = exp_dc + 16'd1;
    end else if (c) begin
      exp_ovf = 1'b0;
      exp_dc  = '0;
    end
  endtask

  task automatic compare_outputs();
    logic [PW+2:0] h;
    check_eq("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() > 0));
    check_eq("dbg_state", 32'(dbg_state), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check_eq("tdata", 32'(m_axis_tdata), 32'(h[PW+2:3]));
      check_eq("tuser", 32'(m_axis_tuser), 32'(h[2]));
      check_eq("tlast", 32'(m_axis_tlast), 32'(h[1]));
    end
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
`ifdef PIXEL_STREAM_FRAMER_STATS_EN
    check_eq("drop_count", 32'(drop_count), 32'(exp_dc));
`endif
  endtask

  // driver: check what the DUT shows now, then present inputs for the next rising edge
  task automatic cycle(input bit v, input logic [PW-1:0] d, input bit r, input bit c);
    @(negedge clk);
    compare_outputs();
    s_pixel_valid = v;
    s_pixel_data  = d;
    m_axis_tready = r;
    clr_overflow  = c;
    model_step(v, d, r, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn        = 1'b0;
    s_pixel_valid = 1'b0;
    s_pixel_data  = '0;
    m_axis_tready = 1'b0;
    clr_overflow  = 1'b0;
    model_clear();
    #2;
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_tuser", 32'(m_axis_tuser), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int rate;
    n_vec = 0;
    n_err = 0;
    model_clear();
    do_reset();

    // geometry: one full frame streamed with tready high
    for (int i = 0; i < TOTAL; i++) cycle(1'b1, PW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // back-pressure: 5 pixels during 10 stalled cycles, then release
    for (int i = 0; i < 10; i++) cycle(i < 5, PW'(16'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // overflow: 7 pixels into a stalled block, 2 dropped
    for (int i = 0; i < 7; i++) cycle(1'b1, PW'(16'h200 + i), 1'b0, 1'b0);
    // clear coincident with a fresh drop keeps overflow set
    cycle(1'b1, 16'h2AA, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    // full FIFO: one read coincident with a write, no drop
    cycle(1'b1, 16'h2BB, 1'b1, 1'b0);
    cycle(1'b1, 16'h2CC, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    // finish out the frame so the next one starts with sof
    while (pix_n % TOTAL != 0) cycle(1'b1, PW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, PW'(16'h300 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // reset mid-frame after pixel 5
    for (int i = 0; i < 6; i++) cycle(1'b1, PW'(16'h400 + i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, PW'(16'h500 + i), 1'b1, 1'b0);

    // random traffic with varying downstream ready rates and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rate = (i / 250) % 4 == 0 ? 20 : (i / 250) % 4 == 1 ? 100 : (i / 250) % 4 == 2 ? 60 : 85;
      cycle($urandom_range(0, 3) != 0, PW'($urandom),
            $urandom_range(0, 99) < rate, $urandom_range(0, 15) == 0);
      if (i % 1100 == 1099) do_reset();
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
